// File: rtl/rv32_decode_pkg.sv
// Shared types and encodings for the RV32I decode stage: op classes, opcodes,
// funct fields, exact SYSTEM encodings and the registered decode record.
package rv32_decode_pkg;

  typedef enum logic [4:0] {
    OpLui, OpAuipc, OpJal, OpJalr, OpBranch, OpLoad, OpStore, OpOpImm,
    OpOp, OpFence, OpFenceI, OpCsr, OpEcall, OpEbreak, OpMret, OpWfi
  } op_class_t;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OPIMM    = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_FENCE   = 3'b000;
  localparam logic [2:0] F3_FENCEI  = 3'b001;
  localparam logic [2:0] F3_PRIV    = 3'b000;
  localparam logic [2:0] F3_SYS_BAD = 3'b100;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] IR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] IR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] IR_MRET   = 32'h3020_0073;
  localparam logic [31:0] IR_WFI    = 32'h1050_0073;

  typedef struct packed {
    logic [31:0] pc;
    op_class_t   op;
    logic [2:0]  funct3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
  } decode_t;

endpackage

// File: rtl/rv32_decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle.
// master drives fetch offers and execute ready; slave is the decode stage.
interface rv32_decode_stage_if;
  import rv32_decode_pkg::*;

  logic [31:0] fetch_pc;
  logic [31:0] fetch_ir;
  logic        fetch_vld;
  logic        fetch_rdy;
  logic [31:0] decode_pc;
  op_class_t   decode_op;
  logic [2:0]  decode_funct3;
  logic        decode_alt;
  logic [4:0]  decode_rd;
  logic [4:0]  decode_rs1;
  logic [4:0]  decode_rs2;
  logic [31:0] decode_imm;
  logic        decode_illegal;
  logic        decode_vld;
  logic        decode_rdy;

  modport master (
    output fetch_pc, fetch_ir, fetch_vld, decode_rdy,
    input  fetch_rdy, decode_pc, decode_op, decode_funct3, decode_alt, decode_rd,
           decode_rs1, decode_rs2, decode_imm, decode_illegal, decode_vld
  );

  modport slave (
    input  fetch_pc, fetch_ir, fetch_vld, decode_rdy,
    output fetch_rdy, decode_pc, decode_op, decode_funct3, decode_alt, decode_rd,
           decode_rs1, decode_rs2, decode_imm, decode_illegal, decode_vld
  );
endinterface

// File: rtl/rv32_decode_comb.sv
// Purely combinational RV32I field extraction and legality check.
module rv32_decode_comb
  import rv32_decode_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] ir_i,
  output decode_t     dec_o
);

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_csr;
  logic        illegal;

  assign opcode  = ir_i[6:0];
  assign f3      = ir_i[14:12];
  assign f7      = ir_i[31:25];
  assign imm_i   = {{20{ir_i[31]}}, ir_i[31:20]};
  assign imm_s   = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
  assign imm_b   = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
  assign imm_u   = {ir_i[31:12], 12'b0};
  assign imm_j   = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
  assign imm_sh  = {27'b0, ir_i[24:20]};
  assign imm_csr = {20'b0, ir_i[31:20]};

  always_comb begin
    dec_o         = '0;
    dec_o.pc      = pc_i;
    dec_o.op      = OpOpImm;
    dec_o.funct3  = f3;
    dec_o.rd      = ir_i[11:7];
    dec_o.rs1     = ir_i[19:15];
    illegal       = 1'b0;
    case (opcode)
      OP_LUI:   begin dec_o.op = OpLui;   dec_o.rs1 = '0; dec_o.imm = imm_u; end
      OP_AUIPC: begin dec_o.op = OpAuipc; dec_o.rs1 = '0; dec_o.imm = imm_u; end
      OP_JAL:   begin dec_o.op = OpJal;   dec_o.rs1 = '0; dec_o.imm = imm_j; end
      OP_JALR: begin
        dec_o.op  = OpJalr;
        dec_o.imm = imm_i;
        illegal   = (f3 != F3_ADD);
      end
      OP_BRANCH: begin
        dec_o.op  = OpBranch;
        dec_o.rd  = '0;
        dec_o.rs2 = ir_i[24:20];
        dec_o.imm = imm_b;
        illegal   = (f3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        dec_o.op  = OpLoad;
        dec_o.imm = imm_i;
        illegal   = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OP_STORE: begin
        dec_o.op  = OpStore;
        dec_o.rd  = '0;
        dec_o.rs2 = ir_i[24:20];
        dec_o.imm = imm_s;
        illegal   = (f3 >= 3'b011);
      end
      OP_OPIMM: begin
        dec_o.op = OpOpImm;
        if (f3 == F3_SLL || f3 == F3_SR) begin
          dec_o.imm = imm_sh;
          dec_o.alt = ir_i[30];
          illegal   = (f3 == F3_SLL) ? (f7 != F7_ZERO) : (f7 != F7_ZERO && f7 != F7_ALT);
        end else begin
          dec_o.imm = imm_i;
        end
      end
      OP_OP: begin
        dec_o.op  = OpOp;
        dec_o.rs2 = ir_i[24:20];
        dec_o.alt = ir_i[30];
        illegal   = !((f7 == F7_ZERO) || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
      end
      OP_MISC_MEM: begin
        if (f3 == F3_FENCE) begin
          dec_o.op = OpFence;
          dec_o.rd = '0;
        end else if (f3 == F3_FENCEI) begin
          dec_o.op = OpFenceI;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_SYSTEM: begin
        if (f3 == F3_PRIV) begin
          // Only the four exact privileged encodings are legal; operand fields must be 0.
          case (ir_i)
            IR_ECALL:  begin dec_o.op = OpEcall;  dec_o.rd = '0; end
            IR_EBREAK: begin dec_o.op = OpEbreak; dec_o.rd = '0; end
            IR_MRET:   begin dec_o.op = OpMret;   dec_o.rd = '0; end
            IR_WFI:    begin dec_o.op = OpWfi;    dec_o.rd = '0; end
            default:   illegal = 1'b1;
          endcase
        end else if (f3 == F3_SYS_BAD) begin
          illegal = 1'b1;
        end else begin
          dec_o.op  = OpCsr;
          dec_o.imm = imm_csr;
        end
      end
      default: illegal = 1'b1;
    endcase
    if (ir_i[1:0] != 2'b11) illegal = 1'b1;
    if (illegal) dec_o.op = OpOpImm;
    dec_o.illegal = illegal;
  end

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32I decode pipeline stage with valid/ready handshake and flush.
// Define RV32_DECODE_SKID_EN for a one-entry skid buffer and a registered fetch_rdy.
module rv32_decode_stage
  import rv32_decode_pkg::*;
#(
  parameter logic [31:0] BOOT_PC = 32'h0
) (
  input logic               clk,
  input logic               rstz,
  input logic               flush,
  rv32_decode_stage_if.slave bus
);

  localparam decode_t DecReset = '{pc: BOOT_PC, op: OpLui, funct3: 3'b0, alt: 1'b0,
                                   rd: 5'b0, rs1: 5'b0, rs2: 5'b0, imm: 32'b0,
                                   illegal: 1'b0};

  decode_t in_dec, out_q, out_d;
  logic    vld_q, vld_d;
  logic    accept;

  rv32_decode_comb u_comb (
    .pc_i  (bus.fetch_pc),
    .ir_i  (bus.fetch_ir),
    .dec_o (in_dec)
  );

`ifdef RV32_DECODE_SKID_EN
  decode_t skid_q, skid_d;
  logic    skid_vld_q, skid_vld_d;
  logic    can_load;

  assign bus.fetch_rdy = ~skid_vld_q;
  assign accept        = bus.fetch_vld & ~skid_vld_q & ~flush;
  assign can_load      = ~vld_q | bus.decode_rdy;

  always_comb begin
    out_d      = out_q;
    vld_d      = vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      vld_d      = 1'b0;
      skid_vld_d = 1'b0;
    end else if (can_load) begin
      // A full skid always drains first; fetch_rdy is low so nothing new competes.
      if (skid_vld_q) begin
        out_d      = skid_q;
        vld_d      = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_d = in_dec;
        vld_d = 1'b1;
      end else begin
        vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = in_dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      skid_q     <= DecReset;
      skid_vld_q <= 1'b0;
    end else begin
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end
`else
  assign bus.fetch_rdy = ~vld_q | bus.decode_rdy | flush;
  assign accept        = bus.fetch_vld & bus.fetch_rdy & ~flush;

  always_comb begin
    out_d = out_q;
    vld_d = vld_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (accept) begin
      out_d = in_dec;
      vld_d = 1'b1;
    end else if (vld_q & bus.decode_rdy) begin
      vld_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      out_q <= DecReset;
      vld_q <= 1'b0;
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign bus.decode_pc      = out_q.pc;
  assign bus.decode_op      = out_q.op;
  assign bus.decode_funct3  = out_q.funct3;
  assign bus.decode_alt     = out_q.alt;
  assign bus.decode_rd      = out_q.rd;
  assign bus.decode_rs1     = out_q.rs1;
  assign bus.decode_rs2     = out_q.rs2;
  assign bus.decode_imm     = out_q.imm;
  assign bus.decode_illegal = out_q.illegal;
  assign bus.decode_vld     = vld_q;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Self-checking bench for rv32_decode_stage: vector table, scoreboard queue and
// directed stall / flush / asynchronous-reset sequences.
module tb_rv32_decode_stage;
  import rv32_decode_pkg::*;

  localparam logic [31:0] BootPc = 32'h0000_0400;
  localparam int NumVec = 18;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    op_class_t   op;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  logic clk = 1'b0;
  logic rstz = 1'b0;
  logic flush = 1'b0;
  logic rdy_rand = 1'b0;
  logic rdy_force = 1'b0;

  vec_t vecs [NumVec];
  vec_t cur;
  vec_t exp_e;
  vec_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  int   out_cnt = 0;

  rv32_decode_stage_if bus ();

  rv32_decode_stage #(.BOOT_PC(BootPc)) dut (
    .clk   (clk),
    .rstz  (rstz),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    bus.decode_rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic check_out(input vec_t e, input string name);
    checks++;
    if (bus.decode_pc !== e.pc || bus.decode_op !== e.op || bus.decode_funct3 !== e.f3 ||
        bus.decode_alt !== e.alt || bus.decode_rd !== e.rd || bus.decode_rs1 !== e.rs1 ||
        bus.decode_rs2 !== e.rs2 || bus.decode_imm !== e.imm ||
        bus.decode_illegal !== e.ill) begin
      errors++;
      $display("FAIL %s ir=%h: got pc=%h op=%0d f3=%0d alt=%b rd=%0d rs1=%0d rs2=%0d imm=%h ill=%b, want pc=%h op=%0d f3=%0d alt=%b rd=%0d rs1=%0d rs2=%0d imm=%h ill=%b",
               name, e.ir, bus.decode_pc, bus.decode_op, bus.decode_funct3, bus.decode_alt,
               bus.decode_rd, bus.decode_rs1, bus.decode_rs2, bus.decode_imm,
               bus.decode_illegal, e.pc, e.op, e.f3, e.alt, e.rd, e.rs1, e.rs2, e.imm, e.ill);
    end
  endtask

  // Scoreboard: pop on transfer out, push on transfer in, drop everything on flush/reset.
  always @(negedge clk) begin
    if (!rstz) begin
      exp_q.delete();
    end else begin
      if (bus.decode_vld && bus.decode_rdy) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pc=%h, want no output", bus.decode_pc);
        end else begin
          exp_e = exp_q.pop_front();
          check_out(exp_e, "scoreboard");
        end
      end
      if (flush) exp_q.delete();
      else if (bus.fetch_vld && bus.fetch_rdy) begin
        acc_cnt++;
        exp_q.push_back(cur);
      end
    end
  end

  task automatic drive(input int idx);
    cur           = vecs[idx];
    bus.fetch_pc  = vecs[idx].pc;
    bus.fetch_ir  = vecs[idx].ir;
    bus.fetch_vld = 1'b1;
  endtask

  task automatic offer(input int idx);
    bit done = 0;
    drive(idx);
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (bus.fetch_rdy && !flush) done = 1;
      @(posedge clk);
      #1;
    end
    bus.fetch_vld = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL offer_timeout: vector %0d not accepted, want accept within 100 cycles", idx);
    end
  endtask

  task automatic drain();
    int k = 0;
    rdy_rand  = 1'b0;
    rdy_force = 1'b1;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outputs pending, want 0", exp_q.size());
    end
  endtask

  task automatic check_reset(input string name);
    chk({name, "_vld"}, {31'b0, bus.decode_vld}, 32'h0);
    chk({name, "_pc"}, bus.decode_pc, BootPc);
    chk({name, "_imm"}, bus.decode_imm, 32'h0);
    chk({name, "_fields"}, {7'b0, bus.decode_op, bus.decode_funct3, bus.decode_alt,
         bus.decode_rd, bus.decode_rs1, bus.decode_rs2, bus.decode_illegal}, 32'h0);
  endtask

  initial begin
    int acc0, out0;
    vecs[0]  = '{32'h100, 32'hFFB10093, OpOpImm,  3'd0, 1'b0, 5'd1,  5'd2, 5'd0, 32'hFFFFFFFB, 1'b0};
    vecs[1]  = '{32'h104, 32'hFE208CE3, OpBranch, 3'd0, 1'b0, 5'd0,  5'd1, 5'd2, 32'hFFFFFFF8, 1'b0};
    vecs[2]  = '{32'h108, 32'h001000EF, OpJal,    3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'h00000800, 1'b0};
    vecs[3]  = '{32'h10C, 32'h00000000, OpOpImm,  3'd0, 1'b0, 5'd0,  5'd0, 5'd0, 32'h00000000, 1'b1};
    vecs[4]  = '{32'h110, 32'h30200073, OpMret,   3'd0, 1'b0, 5'd0,  5'd0, 5'd0, 32'h00000000, 1'b0};
    vecs[5]  = '{32'h114, 32'h40209093, OpOpImm,  3'd1, 1'b1, 5'd1,  5'd1, 5'd0, 32'h00000002, 1'b1};
    vecs[6]  = '{32'h118, 32'h123452B7, OpLui,    3'd5, 1'b0, 5'd5,  5'd0, 5'd0, 32'h12345000, 1'b0};
    vecs[7]  = '{32'h11C, 32'h0020A623, OpStore,  3'd2, 1'b0, 5'd0,  5'd1, 5'd2, 32'h0000000C, 1'b0};
    vecs[8]  = '{32'h120, 32'h40725193, OpOpImm,  3'd5, 1'b1, 5'd3,  5'd4, 5'd0, 32'h00000007, 1'b0};
    vecs[9]  = '{32'h124, 32'h407302B3, OpOp,     3'd0, 1'b1, 5'd5,  5'd6, 5'd7, 32'h00000000, 1'b0};
    vecs[10] = '{32'h128, 32'h407312B3, OpOpImm,  3'd1, 1'b1, 5'd5,  5'd6, 5'd7, 32'h00000000, 1'b1};
    vecs[11] = '{32'h12C, 32'h3052D0F3, OpCsr,    3'd5, 1'b0, 5'd1,  5'd5, 5'd0, 32'h00000305, 1'b0};
    vecs[12] = '{32'h130, 32'hFFC4A403, OpLoad,   3'd2, 1'b0, 5'd8,  5'd9, 5'd0, 32'hFFFFFFFC, 1'b0};
    vecs[13] = '{32'h134, 32'h000110E7, OpOpImm,  3'd1, 1'b0, 5'd1,  5'd2, 5'd0, 32'h00000000, 1'b1};
    vecs[14] = '{32'h138, 32'h10500073, OpWfi,    3'd0, 1'b0, 5'd0,  5'd0, 5'd0, 32'h00000000, 1'b0};
    vecs[15] = '{32'h13C, 32'hFFFFF517, OpAuipc,  3'd7, 1'b0, 5'd10, 5'd0, 5'd0, 32'hFFFFF000, 1'b0};
    vecs[16] = '{32'h140, 32'h0000100F, OpFenceI, 3'd1, 1'b0, 5'd0,  5'd0, 5'd0, 32'h00000000, 1'b0};
    vecs[17] = '{32'h144, 32'hFFB10092, OpOpImm,  3'd0, 1'b0, 5'd1,  5'd2, 5'd0, 32'h00000000, 1'b1};

    cur           = vecs[0];
    bus.fetch_pc  = 32'h0;
    bus.fetch_ir  = 32'h0;
    bus.fetch_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    chk("reset_fetch_rdy", {31'b0, bus.fetch_rdy}, 32'h1);
    rstz = 1'b1;
    @(posedge clk);
    #1;

    // Stall: first instruction held for 5 cycles while the next one is offered.
    rdy_force = 1'b0;
    out0 = out_cnt;
    offer(0);
    acc0 = acc_cnt;
    drive(1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_out(vecs[0], "stall_hold");
      chk("stall_vld", {31'b0, bus.decode_vld}, 32'h1);
`ifdef RV32_DECODE_SKID_EN
      chk("stall_fetch_rdy", {31'b0, bus.fetch_rdy}, (k == 0) ? 32'h1 : 32'h0);
`else
      chk("stall_fetch_rdy", {31'b0, bus.fetch_rdy}, 32'h0);
`endif
      @(posedge clk);
      #1;
      if (acc_cnt != acc0) bus.fetch_vld = 1'b0;
    end
`ifdef RV32_DECODE_SKID_EN
    chk("stall_accepts", acc_cnt - acc0, 32'd1);
`else
    chk("stall_accepts", acc_cnt - acc0, 32'd0);
`endif
    rdy_force = 1'b1;
    for (int k = 0; k < 20 && acc_cnt == acc0; k++) begin
      @(posedge clk);
      #1;
    end
    bus.fetch_vld = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("stall_out_count", out_cnt - out0, 32'd2);

    // Full vector table under random execute back-pressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < NumVec; i++) offer(i);
    drain();

    // Flush while stalled with a held (and, with skid, a buffered) instruction.
    rdy_force = 1'b0;
    offer(2);
    acc0 = acc_cnt;
    drive(6);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != acc0) bus.fetch_vld = 1'b0;
    end
    drive(15);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_pre_vld", {31'b0, bus.decode_vld}, 32'h1);
`ifndef RV32_DECODE_SKID_EN
    chk("flush_fetch_rdy", {31'b0, bus.fetch_rdy}, 32'h1);
`endif
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.fetch_vld = 1'b0;
    rdy_force = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("flush_vld", {31'b0, bus.decode_vld}, 32'h0);
    end
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a stream, then recovery.
    fork
      begin
        for (int i = 0; i < 8; i++) offer(i);
      end
      begin
        repeat (4) @(posedge clk);
        #3;
        chk("pre_reset_vld", {31'b0, bus.decode_vld}, 32'h1);
        rstz = 1'b0;
        #1;
        check_reset("async_reset");
        @(posedge clk);
        #3;
        rstz = 1'b1;
      end
    join
    drain();
    rdy_rand = 1'b1;
    for (int i = 8; i < NumVec; i++) offer(i);
    drain();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
